// File: rtl/env_adsr_pkg.sv
// Shared constants for the ADSR envelope generator: default widths, full-scale
// amplitude and the phase encoding reported on o_state.
package env_adsr_pkg;

    localparam int unsigned W_DEF       = 16;
    localparam int unsigned AMP_MAX_DEF = 32'h0000_7fff;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StAttack  = 3'd1,
        StDecay   = 3'd2,
        StSustain = 3'd3,
        StRelease = 3'd4
    } adsr_state_e;

endpackage

// File: rtl/env_sat_step.sv
// Saturating step of val_i by step_i toward lim_i (up or down). A zero step jumps
// straight to the limit; reached_o flags that the result sits on the limit.
module env_sat_step #(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0] val_i,
    input  logic [W-1:0] step_i,
    input  logic [W-1:0] lim_i,
    input  logic         up_i,
    output logic [W-1:0] res_o,
    output logic         reached_o
);

    logic [W:0] sum;
    logic [W:0] diff;

    // One extra bit catches carry on the way up and borrow on the way down.
    assign sum  = {1'b0, val_i} + {1'b0, step_i};
    assign diff = {1'b0, val_i} - {1'b0, step_i};

    always_comb begin
        res_o = lim_i;
        if (step_i != '0) begin
            if (up_i) begin
                if (sum < {1'b0, lim_i}) res_o = sum[W-1:0];
            end else begin
                if (!diff[W] && (diff[W-1:0] > lim_i)) res_o = diff[W-1:0];
            end
        end
    end

    assign reached_o = (res_o == lim_i);

endmodule

// File: rtl/env_adsr.sv
// ADSR envelope generator: gate-driven phase FSM stepping o_amp once per i_tick.
// Define ENV_ADSR_LEGATO_EN to retrigger ATTACK from the current amplitude.
module env_adsr
    import env_adsr_pkg::*;
#(
    parameter int unsigned  W       = W_DEF,
    parameter logic [W-1:0] AMP_MAX = W'(AMP_MAX_DEF)
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_tick,
    input  logic         i_gate,
    input  logic [W-1:0] i_attack_rate,
    input  logic [W-1:0] i_decay_rate,
    input  logic [W-1:0] i_release_rate,
    input  logic [W-1:0] i_sustain_level,
    output logic [W-1:0] o_amp,
    output logic [2:0]   o_state,
    output logic         o_active,
    output logic         o_done
);

    adsr_state_e  state_q, state_d;
    logic [W-1:0] amp_q, amp_d;
    logic         done_q, done_d;
    logic         gate_q;
    logic         gate_rise, gate_fall;
    logic [W-1:0] sus_lvl, step, lim, step_res;
    logic         step_up, step_hit;

    assign gate_rise = i_gate & ~gate_q;
    assign gate_fall = ~i_gate & gate_q;
    assign sus_lvl   = (i_sustain_level > AMP_MAX) ? AMP_MAX : i_sustain_level;

    // Select the step and target of the current phase for the shared stepper.
    always_comb begin
        step    = '0;
        lim     = '0;
        step_up = 1'b0;
        case (state_q)
            StAttack: begin
                step    = i_attack_rate;
                lim     = AMP_MAX;
                step_up = 1'b1;
            end
            StDecay: begin
                step = i_decay_rate;
                lim  = sus_lvl;
            end
            StSustain: lim  = sus_lvl;
            StRelease: step = i_release_rate;
            default: ;
        endcase
    end

    env_sat_step #(
        .W(W)
    ) u_sat_step (
        .val_i    (amp_q),
        .step_i   (step),
        .lim_i    (lim),
        .up_i     (step_up),
        .res_o    (step_res),
        .reached_o(step_hit)
    );

    always_comb begin
        state_d = state_q;
        amp_d   = amp_q;
        done_d  = 1'b0;
        if (gate_rise) begin
            state_d = StAttack;
`ifdef ENV_ADSR_LEGATO_EN
            amp_d   = amp_q;
`else
            amp_d   = '0;
`endif
        end else if (gate_fall) begin
            if (state_q inside {StAttack, StDecay, StSustain}) state_d = StRelease;
        end else if (i_tick) begin
            case (state_q)
                StAttack: begin
                    amp_d = step_res;
                    if (step_hit) state_d = StDecay;
                end
                StDecay: begin
                    amp_d = step_res;
                    if (step_hit) state_d = StSustain;
                end
                StSustain: amp_d = step_res;
                StRelease: begin
                    amp_d = step_res;
                    if (step_hit) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
                default: amp_d = '0;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            amp_q   <= '0;
            done_q  <= 1'b0;
            gate_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            amp_q   <= amp_d;
            done_q  <= done_d;
            gate_q  <= i_gate;
        end
    end

    assign o_amp    = amp_q;
    assign o_state  = state_q;
    assign o_active = (state_q != StIdle);
    assign o_done   = done_q;

endmodule

// File: tb/tb_env_adsr.sv
// Directed bench for env_adsr: full ADSR note, live sustain, retrigger, zero rates,
// sustain clamping, edge-over-tick priority and asynchronous reset.
module tb_env_adsr;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tick;
    logic        gate;
    logic [15:0] attack_rate, decay_rate, release_rate, sustain_level;
    logic [15:0] amp;
    logic [2:0]  state;
    logic        active;
    logic        done;

    int n_total = 0;
    int n_bad   = 0;

`ifdef ENV_ADSR_LEGATO_EN
    localparam bit Legato = 1'b1;
`else
    localparam bit Legato = 1'b0;
`endif

    always #5 clk = ~clk;

    env_adsr u_dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_tick         (tick),
        .i_gate         (gate),
        .i_attack_rate  (attack_rate),
        .i_decay_rate   (decay_rate),
        .i_release_rate (release_rate),
        .i_sustain_level(sustain_level),
        .o_amp          (amp),
        .o_state        (state),
        .o_active       (active),
        .o_done         (done)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    // Three quiet clocks then a one-cycle tick: one tick every four clocks.
    task automatic pulse_tick();
        repeat (3) step_clk();
        tick = 1'b1;
        step_clk();
        tick = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_amp;
        rst_n         = 1'b0;
        tick          = 1'b0;
        gate          = 1'b0;
        attack_rate   = 16'h1000;
        decay_rate    = 16'h0800;
        release_rate  = 16'h1000;
        sustain_level = 16'h3fff;
        repeat (2) step_clk();
        check_val("rst_amp", amp, 0);
        check_val("rst_state", state, 0);
        check_val("rst_active", active, 0);
        check_val("rst_done", done, 0);
        rst_n = 1'b1;
        step_clk();

        // Attack ramp
        gate = 1'b1;
        step_clk();
        check_val("rise_state", state, 1);
        check_val("rise_amp", amp, 0);
        check_val("rise_active", active, 1);
        for (int k = 1; k <= 8; k++) begin
            pulse_tick();
            exp_amp = (k * 32'h1000 > 32'h7fff) ? 32'h7fff : k * 32'h1000;
            check_val("atk_amp", amp, exp_amp);
            check_val("atk_state", state, (k == 8) ? 2 : 1);
        end

        // Decay down to sustain
        for (int k = 1; k <= 8; k++) begin
            pulse_tick();
            check_val("dec_amp", amp, 32'h7fff - k * 32'h0800);
            check_val("dec_state", state, (k == 8) ? 3 : 2);
        end

        // Live sustain change lands only on the next tick
        sustain_level = 16'h2000;
        step_clk();
        check_val("sus_hold", amp, 32'h3fff);
        pulse_tick();
        check_val("sus_new", amp, 32'h2000);
        check_val("sus_state", state, 3);

        // Release to idle with a single done pulse
        gate = 1'b0;
        step_clk();
        check_val("fall_state", state, 4);
        check_val("fall_amp", amp, 32'h2000);
        pulse_tick();
        check_val("rel1_amp", amp, 32'h1000);
        check_val("rel1_done", done, 0);
        pulse_tick();
        check_val("rel2_amp", amp, 0);
        check_val("rel2_state", state, 0);
        check_val("rel2_done", done, 1);
        step_clk();
        check_val("done_clr", done, 0);

        // Zero rates reach each target in one tick; retrigger during release
        attack_rate = 16'h0000;
        gate = 1'b1;
        step_clk();
        pulse_tick();
        check_val("z_atk_amp", amp, 32'h7fff);
        check_val("z_atk_state", state, 2);
        decay_rate    = 16'h0000;
        sustain_level = 16'h1800;
        pulse_tick();
        check_val("z_dec_amp", amp, 32'h1800);
        check_val("z_dec_state", state, 3);
        gate = 1'b0;
        step_clk();
        check_val("rel_state", state, 4);
        gate = 1'b1;
        step_clk();
        check_val("retrig_state", state, 1);
        check_val("retrig_amp", amp, Legato ? 32'h1800 : 32'h0);
        attack_rate = 16'h1000;
        pulse_tick();
        check_val("retrig_step", amp, Legato ? 32'h2800 : 32'h1000);

        // Sustain above full scale clamps; decay completes on first tick
        sustain_level = 16'hffff;
        attack_rate   = 16'h0000;
        decay_rate    = 16'h0800;
        pulse_tick();
        check_val("clamp_atk", state, 2);
        pulse_tick();
        check_val("clamp_amp", amp, 32'h7fff);
        check_val("clamp_state", state, 3);
        release_rate = 16'h0000;
        gate = 1'b0;
        step_clk();
        pulse_tick();
        check_val("zrel_amp", amp, 0);
        check_val("zrel_state", state, 0);
        check_val("zrel_done", done, 1);

        // Idle ignores ticks
        pulse_tick();
        check_val("idle_amp", amp, 0);
        check_val("idle_state", state, 0);

        // Edge beats a coincident tick
        attack_rate = 16'h1000;
        gate = 1'b1;
        tick = 1'b1;
        step_clk();
        tick = 1'b0;
        check_val("prio_amp", amp, 0);
        check_val("prio_state", state, 1);
        pulse_tick();
        check_val("prio_next", amp, 32'h1000);

        // Asynchronous reset between edges, mid-attack
        #3;
        rst_n = 1'b0;
        #1;
        check_val("arst_amp", amp, 0);
        check_val("arst_state", state, 0);
        check_val("arst_active", active, 0);
        step_clk();
        rst_n = 1'b1;
        step_clk();
        check_val("rel_gate_rise", state, 1);
        check_val("rel_gate_amp", amp, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
